retire_unit: RTL and testbench

RETIRE_UNIT -- requirements
Module: retire_unit

---
 rtl/retire_unit_pkg.sv | 16 +
 rtl/retire_unit.sv | 101 ++++++++++
 tb/tb_retire_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/retire_unit_pkg.sv
// retire_unit_pkg: retire FSM states and ROB entry layout shared by the retire unit and its users
package retire_unit_pkg;
  localparam int RU_PHYS_W = 6;
  localparam int RU_XLEN = 32;
  typedef enum logic [1:0] {RUN, STORE_REQ, FLUSH, DRAIN} retire_state_t;
  typedef struct packed {
    logic                 uses_rd;
    logic [4:0]           rd_arch;
    logic [RU_PHYS_W-1:0] pd_new;
    logic                 is_store;
    logic                 is_branch;
    logic                 mispredict;
    logic [RU_XLEN-1:0]   redirect_pc;
    logic [1:0]           epoch;
  } rob_entry_t;
endpackage

// File: rtl/retire_unit.sv
// retire_unit: in-order ROB head retirement with store release, mispredict flush/redirect and drain
module retire_unit
  import retire_unit_pkg::*;
#(
  parameter int ROB_SIZE  = 16,
  parameter int PHYS_REGS = 64,
  parameter int ROB_W     = $clog2(ROB_SIZE),
  parameter int PHYS_W    = $clog2(PHYS_REGS),
  parameter int XLEN      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  rob_entry_t        commit_entry,
  input  logic [ROB_W-1:0]  commit_rob_idx,
  output logic              st_commit_valid,
  input  logic              st_commit_ready,
  output logic [ROB_W-1:0]  st_commit_rob_idx,
  output logic              arch_wr_valid,
  output logic [4:0]        arch_wr_rd,
  output logic [PHYS_W-1:0] arch_wr_pd,
  output logic              flush_valid,
  output logic [ROB_W-1:0]  flush_rob_idx,
  output logic [1:0]        flush_epoch,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic [1:0]        global_epoch,
  input  logic              recover_valid,
  output logic [31:0]       retire_count
);
  retire_state_t state, state_nx;
  logic [ROB_W-1:0] st_idx_q, fl_idx_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0] count_q;
  logic stale, is_mp, retire;
  assign stale = commit_entry.epoch != global_epoch;
  assign is_mp = commit_entry.is_branch & commit_entry.mispredict;
  // retire marks non-stale retirements, which are the only ones counted
  always_comb begin
    state_nx = state;
    commit_ready = 1'b0;
    retire = 1'b0;
    st_commit_valid = 1'b0;
    flush_valid = 1'b0;
    case (state)
      RUN: if (commit_valid) begin
        if (stale) commit_ready = 1'b1;
        else if (commit_entry.is_store) state_nx = STORE_REQ;
        else begin
          commit_ready = 1'b1;
          retire = 1'b1;
          state_nx = is_mp ? FLUSH : RUN;
        end
      end
      STORE_REQ: begin
        st_commit_valid = 1'b1;
        commit_ready = st_commit_ready & commit_valid;
        retire = st_commit_ready & commit_valid;
        state_nx = st_commit_ready ? RUN : STORE_REQ;
      end
      FLUSH: begin
        flush_valid = 1'b1;
        state_nx = DRAIN;
      end
      default: state_nx = recover_valid ? DRAIN : RUN;
    endcase
    if (rst) begin
      commit_ready = 1'b0;
      retire = 1'b0;
      st_commit_valid = 1'b0;
      flush_valid = 1'b0;
    end
  end
  assign arch_wr_valid = retire & (state == RUN) & commit_entry.uses_rd;
  assign arch_wr_rd = arch_wr_valid ? commit_entry.rd_arch : 5'd0;
  assign arch_wr_pd = arch_wr_valid ? PHYS_W'(commit_entry.pd_new) : '0;
  assign st_commit_rob_idx = st_idx_q;
  assign redirect_valid = flush_valid;
  assign flush_rob_idx = fl_idx_q;
  assign flush_epoch = flush_valid ? global_epoch + 2'd1 : 2'd0;
  assign redirect_pc = pc_q;
  assign retire_count = count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      st_idx_q <= '0;
      fl_idx_q <= '0;
      pc_q <= '0;
      count_q <= '0;
    end else begin
      state <= state_nx;
      if (state == RUN && state_nx == STORE_REQ) st_idx_q <= commit_rob_idx;
      if (state == RUN && state_nx == FLUSH) begin
        fl_idx_q <= commit_rob_idx;
        pc_q <= XLEN'(commit_entry.redirect_pc);
      end
      count_q <= count_q + 32'(retire);
    end
  end
endmodule

// File: tb/tb_retire_unit.sv
// tb_retire_unit: directed scenarios plus randomized heads checked against a transaction-level model
module tb_retire_unit;
  import retire_unit_pkg::*;
  logic clk = 1'b0;
  logic rst, commit_valid, commit_ready, st_commit_valid, st_commit_ready;
  rob_entry_t commit_entry;
  logic [3:0] commit_rob_idx, st_commit_rob_idx, flush_rob_idx;
  logic arch_wr_valid, flush_valid, redirect_valid, recover_valid;
  logic [4:0] arch_wr_rd;
  logic [5:0] arch_wr_pd;
  logic [1:0] flush_epoch, global_epoch;
  logic [31:0] redirect_pc, retire_count;
  int errs = 0, checks = 0;
  logic [31:0] cnt;
  logic exp_fl = 1'b0;
  logic [3:0] exp_fl_idx;
  logic [31:0] exp_pc;
  always #5 clk = ~clk;
  retire_unit dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_entry(commit_entry), .commit_rob_idx(commit_rob_idx),
    .st_commit_valid(st_commit_valid), .st_commit_ready(st_commit_ready),
    .st_commit_rob_idx(st_commit_rob_idx), .arch_wr_valid(arch_wr_valid),
    .arch_wr_rd(arch_wr_rd), .arch_wr_pd(arch_wr_pd), .flush_valid(flush_valid),
    .flush_rob_idx(flush_rob_idx), .flush_epoch(flush_epoch),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .global_epoch(global_epoch), .recover_valid(recover_valid), .retire_count(retire_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic rob_entry_t mk(input logic u, input logic [4:0] rd, input logic [5:0] pd,
      input logic st, input logic br, input logic mp, input logic [31:0] pc, input logic [1:0] ep);
    rob_entry_t e;
    e.uses_rd = u; e.rd_arch = rd; e.pd_new = pd; e.is_store = st;
    e.is_branch = br; e.mispredict = mp; e.redirect_pc = pc; e.epoch = ep;
    return e;
  endfunction
  task automatic gen_chk();
    chk("count", retire_count, cnt);
    chk("flush_v", 32'(flush_valid), 32'(exp_fl));
    chk("redir_v", 32'(redirect_valid), 32'(exp_fl));
    if (exp_fl) begin
      chk("flush_idx", 32'(flush_rob_idx), 32'(exp_fl_idx));
      chk("flush_ep", 32'(flush_epoch), 32'(2'(global_epoch + 2'd1)));
      chk("redir_pc", redirect_pc, exp_pc);
    end
    if (!commit_valid) chk("idle_ready", 32'(commit_ready), 0);
    exp_fl = 1'b0;
  endtask
  initial begin
    rob_entry_t e;
    int kind;
    logic done;
    rst = 1'b1; commit_valid = 1'b1; st_commit_ready = 1'b0; recover_valid = 1'b0;
    global_epoch = 2'd0; commit_rob_idx = 4'd0;
    commit_entry = mk(1, 5'd1, 6'd2, 0, 0, 0, 32'h0, 2'd0);
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ready", 32'(commit_ready), 0);
    chk("rst_aw", 32'(arch_wr_valid), 0);
    chk("rst_stv", 32'(st_commit_valid), 0);
    chk("rst_flv", 32'(flush_valid), 0);
    chk("rst_count", retire_count, 0);
    chk("rst_flidx", 32'(flush_rob_idx), 0);
    chk("rst_flep", 32'(flush_epoch), 0);
    chk("rst_pc", redirect_pc, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      commit_entry = mk(1, 5'(5 + i), 6'(33 + i), 0, 0, 0, 32'h0, 2'd0);
      commit_rob_idx = 4'(i); #1;
      chk("norm_ready", 32'(commit_ready), 1);
      chk("norm_aw", 32'(arch_wr_valid), 1);
      chk("norm_rd", 32'(arch_wr_rd), 32'(5 + i));
      chk("norm_pd", 32'(arch_wr_pd), 32'(33 + i));
      @(negedge clk);
    end
    commit_valid = 1'b0; #1;
    chk("norm_count", retire_count, 3);
    chk("norm_idle", 32'(commit_ready), 0);
    @(negedge clk);
    commit_valid = 1'b1; commit_rob_idx = 4'd4;
    commit_entry = mk(0, 5'd0, 6'd0, 1, 0, 0, 32'h0, 2'd0); #1;
    chk("st_run_ready", 32'(commit_ready), 0);
    chk("st_run_v", 32'(st_commit_valid), 0);
    @(negedge clk);
    commit_rob_idx = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_wait_v", 32'(st_commit_valid), 1);
      chk("st_wait_idx", 32'(st_commit_rob_idx), 4);
      chk("st_wait_ready", 32'(commit_ready), 0);
      @(negedge clk);
    end
    st_commit_ready = 1'b1; #1;
    chk("st_acc_v", 32'(st_commit_valid), 1);
    chk("st_acc_ready", 32'(commit_ready), 1);
    chk("st_acc_aw", 32'(arch_wr_valid), 0);
    @(negedge clk);
    commit_valid = 1'b0; st_commit_ready = 1'b0; #1;
    chk("st_done_v", 32'(st_commit_valid), 0);
    chk("st_count", retire_count, 4);
    @(negedge clk);
    global_epoch = 2'd3; commit_valid = 1'b1; commit_rob_idx = 4'd9; recover_valid = 1'b1;
    commit_entry = mk(1, 5'd10, 6'd40, 0, 1, 1, 32'h100, 2'd3); #1;
    chk("mp_ready", 32'(commit_ready), 1);
    chk("mp_aw", 32'(arch_wr_valid), 1);
    @(negedge clk);
    commit_rob_idx = 4'd10;
    commit_entry = mk(1, 5'd11, 6'd41, 0, 0, 0, 32'h0, 2'd3); #1;
    chk("fl_v", 32'(flush_valid), 1);
    chk("fl_rv", 32'(redirect_valid), 1);
    chk("fl_idx", 32'(flush_rob_idx), 9);
    chk("fl_ep", 32'(flush_epoch), 0);
    chk("fl_pc", redirect_pc, 32'h100);
    chk("fl_ready", 32'(commit_ready), 0);
    chk("fl_count", retire_count, 5);
    @(negedge clk);
    repeat (2) begin
      #1;
      chk("dr_ready", 32'(commit_ready), 0);
      chk("dr_flv", 32'(flush_valid), 0);
      @(negedge clk);
    end
    recover_valid = 1'b0; #1;
    chk("dr_exit_ready", 32'(commit_ready), 0);
    @(negedge clk); #1;
    chk("run_again_ready", 32'(commit_ready), 1);
    chk("run_again_aw", 32'(arch_wr_valid), 1);
    @(negedge clk);
    commit_valid = 1'b0; #1;
    chk("mp_count", retire_count, 6);
    @(negedge clk);
    global_epoch = 2'd2; commit_valid = 1'b1;
    commit_entry = mk(1, 5'd12, 6'd42, 0, 0, 0, 32'h0, 2'd1); #1;
    chk("stale_ready", 32'(commit_ready), 1);
    chk("stale_aw", 32'(arch_wr_valid), 0);
    @(negedge clk);
    commit_entry = mk(0, 5'd0, 6'd0, 1, 0, 0, 32'h0, 2'd1); #1;
    chk("stale_st_ready", 32'(commit_ready), 1);
    chk("stale_st_v", 32'(st_commit_valid), 0);
    @(negedge clk);
    commit_valid = 1'b0; #1;
    chk("stale_count", retire_count, 6);
    chk("stale_st_after", 32'(st_commit_valid), 0);
    @(negedge clk);
    commit_valid = 1'b1; commit_rob_idx = 4'd7;
    commit_entry = mk(0, 5'd0, 6'd0, 1, 0, 0, 32'h0, 2'd2);
    @(negedge clk); #1;
    chk("rs_stv", 32'(st_commit_valid), 1);
    chk("rs_idx", 32'(st_commit_rob_idx), 7);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rs_ready", 32'(commit_ready), 0);
    chk("rs_stv_in_rst", 32'(st_commit_valid), 0);
    @(negedge clk);
    rst = 1'b0; commit_valid = 1'b0; #1;
    chk("rs_stv_after", 32'(st_commit_valid), 0);
    chk("rs_count", retire_count, 0);
    chk("rs_idx0", 32'(st_commit_rob_idx), 0);
    @(negedge clk);
    commit_valid = 1'b1;
    commit_entry = mk(1, 5'd3, 6'd4, 0, 0, 0, 32'h0, 2'd2); #1;
    chk("rs_run_ready", 32'(commit_ready), 1);
    @(negedge clk);
    commit_valid = 1'b0;
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    #1 chk("wrap_pre", retire_count, 32'hFFFF_FFFF);
    @(negedge clk);
    commit_valid = 1'b1; #1;
    chk("wrap_ready", 32'(commit_ready), 1);
    @(negedge clk);
    commit_valid = 1'b0; #1;
    chk("wrap_count", retire_count, 0);
    @(negedge clk);
    cnt = 32'd0;
    for (int ph = 0; ph < 3; ph++) begin
      commit_valid = 1'b0; recover_valid = 1'b0;
      repeat (3) begin #1 gen_chk(); @(negedge clk); end
      global_epoch = 2'($urandom);
      for (int k = 0; k < 40; k++) begin
        e = mk(1'($urandom), 5'($urandom), 6'($urandom), ($urandom % 4) == 0,
               1'($urandom), 1'($urandom), $urandom, global_epoch);
        if ($urandom % 4 == 0) e.epoch = global_epoch + 2'd1 + 2'($urandom % 3);
        kind = (e.epoch != global_epoch) ? 1 : e.is_store ? 2 : (e.is_branch && e.mispredict) ? 3 : 0;
        if ($urandom % 4 == 0) begin
          commit_valid = 1'b0; #1 gen_chk(); @(negedge clk);
        end
        commit_valid = 1'b1; commit_entry = e; commit_rob_idx = 4'($urandom);
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
          st_commit_ready = 1'($urandom); recover_valid = 1'($urandom); #1;
          gen_chk();
          if (st_commit_valid && kind == 2) chk("r_st_idx", 32'(st_commit_rob_idx), 32'(commit_rob_idx));
          if (commit_ready) begin
            done = 1'b1;
            chk("r_aw", 32'(arch_wr_valid), 32'(kind != 1 && e.uses_rd && kind != 2));
            if (kind != 1 && kind != 2 && e.uses_rd) begin
              chk("r_rd", 32'(arch_wr_rd), 32'(e.rd_arch));
              chk("r_pd", 32'(arch_wr_pd), 32'(e.pd_new));
            end
            chk("r_st_hs", 32'(st_commit_valid && st_commit_ready), 32'(kind == 2));
            if (kind != 1) cnt = cnt + 32'd1;
            if (kind == 3) begin
              exp_fl = 1'b1; exp_fl_idx = commit_rob_idx; exp_pc = e.redirect_pc;
            end
          end
          @(negedge clk);
        end
        if (!done) chk("r_timeout", 0, 1);
      end
    end
    commit_valid = 1'b0; recover_valid = 1'b0;
    repeat (3) begin #1 gen_chk(); @(negedge clk); end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
